// File: rtl/nes_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nes_clock_sequencer
// Description : Derives CPU/PPU clock enables, CPU phi2 (M2), CPU reset hold
//               and a CPU cycle counter from the master clock, with NTSC/PAL
//               divider selection and a halt / single-step debug controller.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_clock_sequencer #(
   parameter int NTSC_CPU_DIV = 12,
   parameter int NTSC_PPU_DIV = 4,
   parameter int PAL_CPU_DIV  = 16,
   parameter int PAL_PPU_DIV  = 5,
   parameter int RESET_HOLD   = 8,
   parameter int CNT_W        = 32
) (
   input  logic             MCLK,
   input  logic             RESET,
   input  logic             PAL_MODE,
   input  logic             HALT,
   input  logic             STEP,
   output logic             CPU_CE,
   output logic             PPU_CE,
   output logic             M2,
   output logic             CPU_RESET,
   output logic [CNT_W-1:0] CPU_CYCLES,
   output logic             HALTED
);

   localparam int MAX_CPU_DIV = (NTSC_CPU_DIV > PAL_CPU_DIV) ? NTSC_CPU_DIV : PAL_CPU_DIV;
   localparam int MAX_PPU_DIV = (NTSC_PPU_DIV > PAL_PPU_DIV) ? NTSC_PPU_DIV : PAL_PPU_DIV;
   localparam int CW = $clog2(MAX_CPU_DIV + 1);
   localparam int PW = $clog2(MAX_PPU_DIV + 1);
   localparam int HW = $clog2(RESET_HOLD + 1);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_HALTED = 2'd1,
      S_STEP   = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cdiv;
   logic [PW-1:0] pdiv;
   logic          pal_q;
   logic          step_q;
   logic [HW-1:0] hold_cnt;

   logic [CW-1:0] cpu_last;
   logic [PW-1:0] ppu_last;
   logic [CW-1:0] m2_thresh;
   logic          advance;
   logic          cpu_wrap;
   logic          ppu_wrap;
   logic          step_rise;

   // Divider terminal counts and phi2 low-phase length follow the latched mode
   assign cpu_last  = pal_q ? CW'(PAL_CPU_DIV - 1) : CW'(NTSC_CPU_DIV - 1);
   assign ppu_last  = pal_q ? PW'(PAL_PPU_DIV - 1) : PW'(NTSC_PPU_DIV - 1);
   assign m2_thresh = pal_q ? CW'((PAL_CPU_DIV * 3) / 8) : CW'((NTSC_CPU_DIV * 3) / 8);

   assign advance   = (state != S_HALTED);
   assign cpu_wrap  = advance && (cdiv == cpu_last);
   assign ppu_wrap  = advance && (pdiv == ppu_last);
   assign step_rise = STEP & ~step_q;

   // Enables and M2 are decoded purely from registered state, so they are
   // glitch-free and freeze naturally while the counters hold in HALTED
   assign CPU_CE = cpu_wrap;
   assign PPU_CE = ppu_wrap;
   assign M2     = (cdiv >= m2_thresh);
   assign HALTED = (state == S_HALTED);

   // Dividers, mode latch, cycle counter, CPU reset hold and run/halt/step FSM
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         state      <= S_RUN;
         cdiv       <= '0;
         pdiv       <= '0;
         pal_q      <= PAL_MODE;
         step_q     <= 1'b0;
         hold_cnt   <= '0;
         CPU_RESET  <= 1'b1;
         CPU_CYCLES <= '0;
      end else begin
         step_q <= STEP;

         if (advance) begin
            cdiv <= cpu_wrap ? '0 : cdiv + 1'b1;
            pdiv <= ppu_wrap ? '0 : pdiv + 1'b1;
         end

         if (cpu_wrap) begin
            CPU_CYCLES <= CPU_CYCLES + 1'b1;
            // Mode is only taken at a CPU cycle boundary; a change realigns
            // the PPU divider with the new CPU period
            pal_q <= PAL_MODE;
            if (PAL_MODE != pal_q) begin
               pdiv <= '0;
            end
            if (CPU_RESET) begin
               if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                  CPU_RESET <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         end

         case (state)
            S_RUN: begin
               if (cpu_wrap && HALT) begin
                  state <= S_HALTED;
               end
            end
            S_HALTED: begin
               if (!HALT) begin
                  state <= S_RUN;
               end else if (step_rise) begin
                  state <= S_STEP;
               end
            end
            S_STEP: begin
               // STEP edges seen here are deliberately dropped, not queued
               if (cpu_wrap) begin
                  state <= HALT ? S_HALTED : S_RUN;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nes_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_clock_sequencer
// Description : Directed bench for nes_clock_sequencer. Expected CPU_CE
//               cycle stamps and counter values are queued by the stimulus
//               and consumed by a monitor whenever the DUT issues CPU_CE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_clock_sequencer;

   logic        MCLK;
   logic        RESET;
   logic        PAL_MODE;
   logic        HALT;
   logic        STEP;
   logic        CPU_CE;
   logic        PPU_CE;
   logic        M2;
   logic        CPU_RESET;
   logic [31:0] CPU_CYCLES;
   logic        HALTED;

   logic        cpu_ce4;
   logic        ppu_ce4;
   logic        m2_4;
   logic        cpu_reset4;
   logic [3:0]  cpu_cycles4;
   logic        halted4;

   typedef struct {
      int          stamp;
      logic [63:0] count;
   } ce_exp_t;

   ce_exp_t exp_q[$];
   int      cyc;
   int      ppu_count;
   int      checks;
   int      errors;

   nes_clock_sequencer u_dut (
      .MCLK       (MCLK),
      .RESET      (RESET),
      .PAL_MODE   (PAL_MODE),
      .HALT       (HALT),
      .STEP       (STEP),
      .CPU_CE     (CPU_CE),
      .PPU_CE     (PPU_CE),
      .M2         (M2),
      .CPU_RESET  (CPU_RESET),
      .CPU_CYCLES (CPU_CYCLES),
      .HALTED     (HALTED)
   );

   nes_clock_sequencer #(.CNT_W(4)) u_dut4 (
      .MCLK       (MCLK),
      .RESET      (RESET),
      .PAL_MODE   (PAL_MODE),
      .HALT       (HALT),
      .STEP       (STEP),
      .CPU_CE     (cpu_ce4),
      .PPU_CE     (ppu_ce4),
      .M2         (m2_4),
      .CPU_RESET  (cpu_reset4),
      .CPU_CYCLES (cpu_cycles4),
      .HALTED     (halted4)
   );

   // 10 ns master clock
   initial begin
      MCLK = 1'b0;
      forever #5 MCLK = ~MCLK;
   end

   // Cycle stamp: value N during the interval following the N-th rising edge
   initial cyc = 0;
   always @(posedge MCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ce(input int stamp, input logic [63:0] count);
      ce_exp_t e;
      e.stamp = stamp;
      e.count = count;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   task automatic check_reset_outputs();
      check("rst_cpu_ce",     {63'd0, CPU_CE},    64'd0);
      check("rst_ppu_ce",     {63'd0, PPU_CE},    64'd0);
      check("rst_m2",         {63'd0, M2},        64'd0);
      check("rst_cpu_reset",  {63'd0, CPU_RESET}, 64'd1);
      check("rst_cpu_cycles", {32'd0, CPU_CYCLES}, 64'd0);
      check("rst_halted",     {63'd0, HALTED},    64'd0);
      check("rst_cycles4",    {60'd0, cpu_cycles4}, 64'd0);
   endtask

   // Scoreboard consumer: every CPU_CE must match the next queued expectation
   initial ppu_count = 0;
   always @(negedge MCLK) begin
      if (PPU_CE === 1'b1) ppu_count <= ppu_count + 1;
      if (CPU_CE === 1'b1) begin
         check("ce_expected", {63'd0, exp_q.size() != 0}, 64'd1);
         if (exp_q.size() != 0) begin
            ce_exp_t e;
            e = exp_q.pop_front();
            check("ce_stamp", 64'(cyc), 64'(e.stamp));
            check("ce_count", {32'd0, CPU_CYCLES}, e.count);
         end
      end
   end

   initial begin
      int c0, h, g, c1, p, ph;
      checks = 0;
      errors = 0;
      RESET = 1'b1; PAL_MODE = 1'b0; HALT = 1'b0; STEP = 1'b0;

      // Reset state
      repeat (3) tick();
      check_reset_outputs();

      // NTSC free run after release
      c0 = cyc;
      RESET = 1'b0;
      for (int k = 0; k < 16; k++) push_ce(c0 + 11 + 12 * k, 64'(k));
      for (int i = 0; i < 24; i++) begin
         tick();
         ph = (cyc - c0) % 12;
         check("ntsc_cpu_ce", {63'd0, CPU_CE}, {63'd0, ph == 11});
         check("ntsc_ppu_ce", {63'd0, PPU_CE}, {63'd0, ((cyc - c0) % 4) == 3});
         check("ntsc_m2",     {63'd0, M2},     {63'd0, ph >= 4});
      end

      // CPU reset hold releases one MCLK after the 8th CPU_CE
      wait_cyc(c0 + 95);
      check("hold_cpu_reset_hi", {63'd0, CPU_RESET}, 64'd1);
      tick();
      check("hold_cpu_reset_lo", {63'd0, CPU_RESET}, 64'd0);
      check("hold_cycles",       {32'd0, CPU_CYCLES}, 64'd8);

      // 16 CPU cycles: 4-bit counter wraps to 0
      wait_cyc(c0 + 192);
      check("wrap_cycles32", {32'd0, CPU_CYCLES}, 64'd16);
      check("wrap_cycles4",  {60'd0, cpu_cycles4}, 64'd0);

      // Halt requested mid-cycle: current CPU_CE still issued
      wait_cyc(c0 + 197);
      HALT = 1'b1;
      push_ce(c0 + 203, 64'd16);
      wait_cyc(c0 + 203);
      check("halt_last_ce", {63'd0, CPU_CE}, 64'd1);
      check("halt_not_yet", {63'd0, HALTED}, 64'd0);
      tick();
      check("halt_halted", {63'd0, HALTED}, 64'd1);
      check("halt_m2",     {63'd0, M2},     64'd0);
      check("halt_cycles", {32'd0, CPU_CYCLES}, 64'd17);
      p = ppu_count;
      repeat (30) tick();
      check("halt_no_ppu",   64'(ppu_count), 64'(p));
      check("halt_still",    {63'd0, HALTED}, 64'd1);

      // Single step with a second STEP edge inside the step
      h = cyc;
      STEP = 1'b1;
      push_ce(h + 12, 64'd17);
      tick();
      check("step_active", {63'd0, HALTED}, 64'd0);
      wait_cyc(h + 3); STEP = 1'b0;
      wait_cyc(h + 5); STEP = 1'b1;
      wait_cyc(h + 7); STEP = 1'b0;
      wait_cyc(h + 12);
      check("step_ce", {63'd0, CPU_CE}, 64'd1);
      tick();
      check("step_rehalted", {63'd0, HALTED}, 64'd1);
      check("step_cycles",   {32'd0, CPU_CYCLES}, 64'd18);
      check("step_ppu3",     64'(ppu_count), 64'(p + 3));

      // Resume, then switch to PAL mid-cycle
      repeat (5) tick();
      g = cyc;
      HALT = 1'b0;
      push_ce(g + 12, 64'd18);
      tick();
      check("resume_run", {63'd0, HALTED}, 64'd0);
      wait_cyc(g + 6);
      PAL_MODE = 1'b1;
      push_ce(g + 28, 64'd19);
      push_ce(g + 44, 64'd20);
      wait_cyc(g + 12);
      check("mode_ntsc_done", {63'd0, CPU_CE}, 64'd1);
      for (int i = 0; i < 32; i++) begin
         tick();
         ph = cyc - (g + 13);
         check("pal_cpu_ce", {63'd0, CPU_CE}, {63'd0, (ph % 16) == 15});
         check("pal_ppu_ce", {63'd0, PPU_CE}, {63'd0, (ph % 5) == 4});
         check("pal_m2",     {63'd0, M2},     {63'd0, (ph % 16) >= 6});
      end

      // Halt, step, and abort the step with RESET
      tick();
      HALT = 1'b1;
      push_ce(g + 60, 64'd21);
      wait_cyc(g + 61);
      check("pal_halted", {63'd0, HALTED}, 64'd1);
      wait_cyc(g + 65);
      STEP = 1'b1;
      tick();
      check("pal_step_active", {63'd0, HALTED}, 64'd0);
      wait_cyc(g + 70);
      RESET = 1'b1;
      tick();
      check_reset_outputs();

      // Release in PAL: first CPU_CE on the 16th MCLK
      c1 = cyc;
      RESET = 1'b0; HALT = 1'b0; STEP = 1'b0;
      push_ce(c1 + 15, 64'd0);
      wait_cyc(c1 + 16);
      check("post_abort_cycles", {32'd0, CPU_CYCLES}, 64'd1);
      check("post_abort_hold",   {63'd0, CPU_RESET}, 64'd1);
      check("queue_drained",     64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute guard against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/nes_clock_sequencer.md
NES_CLOCK_SEQUENCER -- requirements
Module: nes_clock_sequencer

Interface
REQ-001 SHALL have parameter NTSC_CPU_DIV, default 12, MCLK cycles per NTSC CPU cycle.
REQ-002 SHALL have parameter NTSC_PPU_DIV, default 4, MCLK cycles per NTSC PPU dot.
REQ-003 SHALL have parameter PAL_CPU_DIV, default 16, MCLK cycles per PAL CPU cycle.
REQ-004 SHALL have parameter PAL_PPU_DIV, default 5, MCLK cycles per PAL PPU dot.
REQ-005 SHALL have parameter RESET_HOLD, default 8, CPU cycles that CPU_RESET is held after RESET release.
REQ-006 SHALL have parameter CNT_W, default 32, width of CPU_CYCLES.
REQ-007 SHALL have port MCLK  input  1  master clock; the only clock.
REQ-008 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port PAL_MODE  input  1  1 = PAL dividers, 0 = NTSC dividers.
REQ-010 SHALL have port HALT  input  1  level request to freeze CPU/PPU enables.
REQ-011 SHALL have port STEP  input  1  rising edge requests one CPU cycle while halted.
REQ-012 SHALL have port CPU_CE  output  1  one-MCLK CPU clock-enable pulse.
REQ-013 SHALL have port PPU_CE  output  1  one-MCLK PPU clock-enable pulse.
REQ-014 SHALL have port M2  output  1  CPU phi2 level.
REQ-015 SHALL have port CPU_RESET  output  1  active-high reset to the CPU core.
REQ-016 SHALL have port CPU_CYCLES  output  CNT_W  count of issued CPU_CE pulses.
REQ-017 SHALL have port HALTED  output  1  high in state HALTED.

Function
REQ-018 SHALL keep counters cdiv (0..CPU_DIV-1) and pdiv (0..PPU_DIV-1), with CPU_DIV/PPU_DIV selected by latched mode register pal_q.
REQ-019 SHALL advance both counters every MCLK in states RUN and STEP; hold both in HALTED.
REQ-020 SHALL assert CPU_CE in exactly the advancing cycles where cdiv == CPU_DIV-1; PPU_CE likewise where pdiv == PPU_DIV-1.
REQ-021 SHALL drive M2 = 0 while cdiv < (CPU_DIV*3)/8, else 1 (NTSC: 4 low, 8 high), held while HALTED.
REQ-022 SHALL implement FSM RUN, HALTED, STEP: RUN->HALTED when HALT=1 at an advancing cycle with cdiv == CPU_DIV-1 (that CPU_CE still issued).
REQ-023 SHALL go HALTED->RUN when HALT=0; HALTED->STEP on STEP rising edge (registered edge detect) while HALT=1.
REQ-024 SHALL leave STEP on the cycle issuing its CPU_CE: to HALTED if HALT=1, else RUN; a step lasts exactly CPU_DIV MCLK cycles.
REQ-025 SHALL ignore STEP edges in RUN and STEP states (no queuing).
REQ-026 SHALL sample PAL_MODE into pal_q only at an advancing cycle with cdiv == CPU_DIV-1; on a pal_q change, both counters restart at 0.
REQ-027 SHALL increment CPU_CYCLES on every CPU_CE, wrapping 2^CNT_W-1 -> 0.
REQ-028 SHALL keep CPU_RESET high from RESET until the cycle after the RESET_HOLD-th CPU_CE following RESET release, then low; CPU_CE/PPU_CE run during this hold.

Reset
REQ-029 SHALL, while RESET=1: cdiv=pdiv=0, CPU_CE=PPU_CE=M2=0, CPU_RESET=1, CPU_CYCLES=0, HALTED=0, state RUN, pal_q <= PAL_MODE, STEP edge detector cleared.
REQ-030 SHALL abort any step or halt on RESET mid-operation; first CPU_CE after release occurs on the CPU_DIV-th MCLK after release.

Verification
REQ-031 SHALL cover NTSC free-run: RESET 1->0, PAL_MODE=0 -> CPU_CE every 12 MCLK, PPU_CE every 4, 3 PPU_CE per CPU_CE, M2 4 low/8 high.
REQ-032 SHALL cover reset hold: RESET release -> CPU_RESET falls one MCLK after 8th CPU_CE; CPU_CYCLES=8 then.
REQ-033 SHALL cover halt/step: HALT=1 mid-cycle -> halt after current CPU_CE, HALTED=1, no enables; one STEP edge -> exactly 1 CPU_CE, 3 PPU_CE, CPU_CYCLES+1, back to HALTED; two STEP edges within a step -> one CPU_CE.
REQ-034 SHALL cover mode switch: PAL_MODE 0->1 mid-cycle -> NTSC period completes, then CPU_CE every 16, PPU_CE every 5, counters restart at 0.
REQ-035 SHALL cover wrap and abort: CNT_W=4, 16 CPU_CE -> CPU_CYCLES=0; RESET during STEP -> all outputs to REQ-029 values next MCLK.
